// File: rtl/mic_spi_sampler.sv
// mic_spi_sampler
//   Front end of the microphone volume-meter path. A rate counter produces a
//   sample tick every CLKS_PER_SAMPLE cycles. Each tick starts one read frame
//   from an ADCS7476-style ADC: 4 leading zeros followed by 12 data bits, MSB
//   first. A frame with a non-zero leading nibble is discarded.
//
// Ports
//   CLOCK        in   system clock, rising edge
//   RESET        in   synchronous, active-high reset
//   enable       in   1 = take samples; 0 = finish the frame in flight, then idle
//   miso         in   ADC serial data
//   cs_n         out  ADC chip select, active low
//   sclk         out  ADC serial clock, idles high
//   sample[11:0] out  last good sample, held between frames
//   sample_valid out  one-cycle pulse when sample updates
//   frame_err    out  one-cycle pulse when a frame is discarded
//   overrun      out  one-cycle pulse when a tick arrives mid-frame
module mic_spi_sampler #(
  parameter int CLKS_PER_SAMPLE = 5000,
  parameter int SCLK_HALF       = 50
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        enable,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int RW = $clog2(CLKS_PER_SAMPLE);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(CLKS_PER_SAMPLE - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

  // A frame takes 32 half periods of SCLK plus setup and done cycles; it must
  // fit inside one sample period.
  generate
    if (34 * SCLK_HALF + 2 >= CLKS_PER_SAMPLE) begin : g_bad_params
      $error("mic_spi_sampler: frame does not fit in one sample period");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;

  state_t        r_state;
  logic [RW-1:0] r_rate;
  logic          r_tick;
  logic [HW-1:0] r_hcnt;
  logic [4:0]    r_bcnt;
  logic [15:0]   r_shift;

  // Rate counter. r_tick is high in the cycle the count has wrapped to 0, so
  // the first tick lands CLKS_PER_SAMPLE cycles after enable rises.
  always_ff @(posedge CLOCK) begin
    if (RESET || !enable) begin
      r_rate <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_rate == RATE_LAST);
      r_rate <= (r_rate == RATE_LAST) ? '0 : r_rate + 1'b1;
    end
  end

  // Frame sequencer; all pin and strobe outputs are registered here.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_hcnt       <= '0;
      r_bcnt       <= '0;
      r_shift      <= '0;
      cs_n         <= 1'b1;
      sclk         <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      // Guard only: a tick outside IDLE is dropped and flagged.
      overrun      <= r_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b1;
          if (r_tick) begin
            r_state <= S_SETUP;
            cs_n    <= 1'b0;
            r_hcnt  <= '0;
          end
        end
        S_SETUP: begin
          if (r_hcnt == HALF_LAST) begin
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            sclk    <= 1'b0;
            r_state <= S_SHIFT;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (sclk && r_bcnt == 5'd16) begin
            // 16th rise just happened: close the frame without another half period.
            r_state <= S_DONE;
            cs_n    <= 1'b1;
            if (r_shift[15:12] == 4'd0) begin
              sample       <= r_shift[11:0];
              sample_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (r_hcnt == HALF_LAST) begin
            r_hcnt <= '0;
            sclk   <= ~sclk;
            // miso is captured on the edge that takes sclk 0->1.
            if (!sclk) begin
              r_shift <= {r_shift[14:0], miso};
              r_bcnt  <= r_bcnt + 1'b1;
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_spi_sampler.sv
module tb_mic_spi_sampler;
  localparam int N = 200;
  localparam int H = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        enable = 1'b0;
  logic        miso = 1'b0;
  logic        cs_n, sclk, sample_valid, frame_err, overrun;
  logic [11:0] sample;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  mic_spi_sampler #(.CLKS_PER_SAMPLE(N), .SCLK_HALF(H)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
    .frame_err(frame_err), .overrun(overrun)
  );

  // ADC model + bus monitor, evaluated mid-cycle. The ADC loads the next
  // queued word when cs_n falls and presents one bit per sclk fall, MSB first.
  logic [15:0] adc_q[$];
  logic [15:0] cur = 16'h0;
  int bidx = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;
  int fall_cyc = 0, rise_cnt = 0, gap_err = 0, n_fall = 0, n_ovr = 0;

  always @(negedge CLOCK) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      cur = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0;
      bidx = 0;
      fall_cyc = cyc;
      rise_cnt = 0;
      gap_err = 0;
      n_fall++;
    end
    if (cs_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0 && bidx < 16) begin
      miso = cur[15-bidx];
      bidx++;
    end
    if (cs_n === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
      rise_cnt++;
      if (cyc != fall_cyc + 2 * H * rise_cnt) gap_err++;
    end
    if (overrun === 1'b1) n_ovr++;
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Count edges until cs_n falls.
  task automatic wait_fall(input string nm, input int exp_n);
    int n = 0;
    while (cs_n !== 1'b0 && n < 400) begin step(1); n++; end
    chk(nm, n, exp_n);
  endtask

  // Wait for a new frame to start and reach k sclk rises.
  task automatic wait_rises(input int k);
    int n = 0;
    while (cs_n !== 1'b0 && n < 400) begin step(1); n++; end
    step(1);
    while (rise_cnt < k && n < 800) begin step(1); n++; end
    if (n >= 800) chk("wait_rises_timeout", 1, 0);
  endtask

  int last_end = 0;

  // Wait for the end of the current frame and check everything about it.
  task automatic wait_end(input logic ev, input logic er, input logic [11:0] es, input bit chkper);
    int n = 0;
    while (!(sample_valid === 1'b1 || frame_err === 1'b1) && n < 1000) begin step(1); n++; end
    if (n >= 1000) begin
      chk("frame_end_timeout", 1, 0);
    end else begin
      chk("sample_valid", sample_valid, ev);
      chk("frame_err", frame_err, er);
      chk("sample", sample, es);
      chk("cs_n_at_end", cs_n, 1);
      chk("sclk_at_end", sclk, 1);
      chk("end_latency", cyc - fall_cyc, 2 * 16 * H + 1);
      chk("sclk_rises", rise_cnt, 16);
      chk("rise_spacing", gap_err, 0);
      if (chkper) chk("frame_period", cyc - last_end, N);
      last_end = cyc;
      step(1);
      chk("valid_one_cycle", sample_valid, 0);
      chk("err_one_cycle", frame_err, 0);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        ev;
    logic        er;
    logic [11:0] es;
  } vec_t;

  vec_t tbl[6];
  logic [15:0] w;
  logic [11:0] exp_samp;
  logic ev, er;
  int bad, nf;

  initial begin
    tbl[0] = '{16'h0FFF, 1'b1, 1'b0, 12'hFFF};
    tbl[1] = '{16'h0001, 1'b1, 1'b0, 12'h001};
    tbl[2] = '{16'h8123, 1'b0, 1'b1, 12'h001};
    tbl[3] = '{16'h0000, 1'b1, 1'b0, 12'h000};
    tbl[4] = '{16'h1FFF, 1'b0, 1'b1, 12'h000};
    tbl[5] = '{16'h0800, 1'b1, 1'b0, 12'h800};

    // Reset state
    RESET = 1'b1; enable = 1'b0;
    step(3);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    RESET = 1'b0;

    // Idle levels with enable low
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || sample_valid !== 1'b0 ||
          frame_err !== 1'b0 || overrun !== 1'b0) bad++;
    end
    chk("idle_levels", bad, 0);

    // Basic read
    adc_q.push_back(16'h0A5C);
    enable = 1'b1;
    wait_fall("first_cs_fall", N + 1);
    wait_end(1'b1, 1'b0, 12'hA5C, 1'b0);

    // Fixed vectors, back-to-back frames
    for (int i = 0; i < 6; i++) begin
      adc_q.push_back(tbl[i].word);
      wait_end(tbl[i].ev, tbl[i].er, tbl[i].es, 1'b1);
    end
    exp_samp = 12'h800;

    // Random words, roughly half with a good leading nibble
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w = w & 16'h0FFF;
      if ((w >> 12) == 16'd0) begin
        ev = 1'b1; er = 1'b0; exp_samp = w[11:0];
      end else begin
        ev = 1'b0; er = 1'b1;
      end
      adc_q.push_back(w);
      wait_end(ev, er, exp_samp, 1'b1);
    end
    chk("no_overrun", n_ovr, 0);

    // Reset after the 7th sclk rise
    adc_q.push_back(16'h0123);
    wait_rises(7);
    RESET = 1'b1;
    step(1);
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_sample", sample, 0);
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_ferr", frame_err, 0);
    RESET = 1'b0;
    adc_q.push_back(16'h0456);
    wait_fall("post_rst_cs_fall", N + 1);
    wait_end(1'b1, 1'b0, 12'h456, 1'b0);

    // Enable drop after the 3rd sclk rise
    adc_q.push_back(16'h0ABC);
    wait_rises(3);
    enable = 1'b0;
    wait_end(1'b1, 1'b0, 12'hABC, 1'b1);
    nf = n_fall;
    step(1000);
    chk("no_fall_disabled", n_fall, nf);
    chk("sample_held", sample, 12'hABC);
    adc_q.push_back(16'h0321);
    enable = 1'b1;
    wait_fall("reenable_cs_fall", N + 1);
    wait_end(1'b1, 1'b0, 12'h321, 1'b0);
    chk("no_overrun_final", n_ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
